diffusion_inv_iter: RTL

//  Iterative inverse of the ASCON linear diffusion layer (pL^-1) for decryption-side tests and key-stream checks.

---
 rtl/diffusion_inv_iter.sv | 107 ++++++++++
 1 files changed

// File: rtl/diffusion_inv_iter.sv
// Iterative inverse of the ASCON linear diffusion layer: applies the six commuting
// factors L_{r,k}, UNROLL per clock, over a valid/ready handshake.
module diffusion_inv_iter #(
    parameter int unsigned UNROLL = 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [4:0][63:0] state_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [4:0][63:0] state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Row rotation constants, index 0 = row 0.
    localparam logic [4:0][5:0] ROT_A = {6'd7,  6'd10, 6'd1, 6'd61, 6'd19};
    localparam logic [4:0][5:0] ROT_B = {6'd41, 6'd17, 6'd6, 6'd39, 6'd28};

    fsm_e             fsm_q, fsm_d;
    logic [2:0]       k_q, k_d;
    logic [4:0][63:0] st_q, st_d;
    logic [4:0][63:0] st_acc;
    logic [3:0]       k_nx;

    function automatic logic [63:0] rotr64(input logic [63:0] x, input logic [5:0] n);
        // A shift by 64 yields zero, so n == 0 degenerates to x.
        return (x >> n) | (x << (7'd64 - {1'b0, n}));
    endfunction

    function automatic logic [4:0][63:0] apply_factor(input logic [4:0][63:0] s,
                                                      input logic [2:0]       k);
        logic [4:0][63:0] res;
        logic [5:0]       sa;
        logic [5:0]       sb;
        res = '0;
        for (int unsigned r = 0; r < 5; r++) begin
            sa = ROT_A[3'(r)] << k;
            sb = ROT_B[3'(r)] << k;
            res[3'(r)] = s[3'(r)] ^ rotr64(s[3'(r)], sa) ^ rotr64(s[3'(r)], sb);
        end
        return res;
    endfunction

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q <= IDLE;
            k_q   <= '0;
            st_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            k_q   <= k_d;
            st_q  <= st_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        k_d     = k_q;
        st_d    = st_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        state_o = st_q;
        k_nx    = {1'b0, k_q} + 4'(UNROLL);
        st_acc  = st_q;
        for (int unsigned j = 0; j < UNROLL; j++) begin
            st_acc = apply_factor(st_acc, k_q + 3'(j));
        end

        case (fsm_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    st_d  = state_i;
                    k_d   = '0;
                    fsm_d = RUN;
                end
            end
            RUN: begin
                st_d = st_acc;
                if (k_nx >= 4'd6) begin
                    k_d   = '0;
                    fsm_d = DONE;
                end else begin
                    k_d = k_nx[2:0];
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
                k_d   = '0;
            end
        endcase
    end

endmodule
